if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_if.sv | 21 ++
 rtl/if_stage.sv | 106 ++++++++++
 tb/tb_if_stage.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Instruction fetch bus between the IF stage (master) and the instruction memory (slave).
interface if_stage_if;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_ack;
  logic [31:0] bus_rd_data;

  modport master (
    output bus_req,
    output bus_addr,
    input  bus_ack,
    input  bus_rd_data
  );

  modport slave (
    input  bus_req,
    input  bus_addr,
    output bus_ack,
    output bus_rd_data
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: one fetch in flight, a one-word skid buffer absorbs an ack that
// arrives while the pipeline is stalled, flush redirects and branches are taken with one
// delay slot.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic [31:0]        new_pc,
  input  logic               br_taken,
  input  logic [31:0]        br_addr,
  if_stage_if.master         bus,
  output logic               busy,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_insn,
  output logic               if_en
);

  // Fetch addresses are always word aligned.
  localparam logic [31:0] AlignMask = 32'hFFFF_FFFC;

  typedef enum logic {
    StReq,
    StHold
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_insn_q, if_insn_d;
  logic        if_en_q, if_en_d;

  logic        advance;
  logic        acked;

  // Fetch bus and busy flag; busy deliberately ignores stall/flush so ctrl can use it freely.
  always_comb begin
    bus.bus_req  = (state_q == StReq) && !reset;
    bus.bus_addr = pc_q;
    busy         = (state_q == StReq) && !bus.bus_ack;
  end

  // Next-state: flush beats stall, stall beats advance; pc only moves on advance or flush.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    skid_d    = skid_q;
    if_pc_d   = if_pc_q;
    if_insn_d = if_insn_q;
    if_en_d   = if_en_q;

    acked   = (state_q == StReq) && bus.bus_ack;
    advance = !flush && !stall && (acked || (state_q == StHold));

    if (flush) begin
      // Concurrent ack data and any buffered word are dropped.
      pc_d      = new_pc & AlignMask;
      state_d   = StReq;
      if_en_d   = 1'b0;
      if_insn_d = NOP_INSN;
    end else if (stall) begin
      if (acked) begin
        skid_d  = bus.bus_rd_data;
        state_d = StHold;
      end
    end else if (advance) begin
      if_pc_d   = pc_q;
      if_en_d   = 1'b1;
      if_insn_d = (state_q == StHold) ? skid_q : bus.bus_rd_data;
      // The word delivered this cycle is the delay slot; the branch redirects the next fetch.
      pc_d      = br_taken ? (br_addr & AlignMask) : (pc_q + 32'd4);
      state_d   = StReq;
    end else begin
      // Waiting on the bus: emit a bubble.
      if_en_d = 1'b0;
    end
  end

  // State registers with synchronous reset that overrides every other request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StReq;
      pc_q      <= RESET_PC & AlignMask;
      skid_q    <= 32'h0;
      if_pc_q   <= 32'h0;
      if_insn_q <= NOP_INSN;
      if_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      skid_q    <= skid_d;
      if_pc_q   <= if_pc_d;
      if_insn_q <= if_insn_d;
      if_en_q   <= if_en_d;
    end
  end

  assign if_pc   = if_pc_q;
  assign if_insn = if_insn_q;
  assign if_en   = if_en_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios with fixed expectations, then randomized traffic
// checked every cycle against a transaction-level model of the fetch stream.
module tb_if_stage;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        br_taken;
  logic [31:0] br_addr;
  logic        busy;
  logic [31:0] if_pc;
  logic [31:0] if_insn;
  logic        if_en;

  if_stage_if bus ();

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSN (Nop)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .flush    (flush),
    .new_pc   (new_pc),
    .br_taken (br_taken),
    .br_addr  (br_addr),
    .bus      (bus.master),
    .busy     (busy),
    .if_pc    (if_pc),
    .if_insn  (if_insn),
    .if_en    (if_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  // Reference model: the next fetch address plus at most one word already fetched but not
  // yet handed on. With a word parked no fetch is requested.
  logic [31:0] m_pc;
  logic [31:0] m_parked[$];
  logic [31:0] m_if_pc;
  logic [31:0] m_if_insn;
  logic        m_if_en;

  task automatic deliver(input logic [31:0] word, input bit br, input logic [31:0] baddr);
    m_if_pc   = m_pc;
    m_if_insn = word;
    m_if_en   = 1'b1;
    m_pc      = br ? (baddr & 32'hFFFF_FFFC) : m_pc + 32'd4;
  endtask

  // One clock: drive inputs, check the combinational outputs, advance the model, check the
  // registered outputs after the edge.
  task automatic cycle(input bit rst, input bit st, input bit fl, input logic [31:0] npc,
                       input bit br, input logic [31:0] baddr, input bit ack,
                       input logic [31:0] data);
    bit fetching;
    reset           = rst;
    stall           = st;
    flush           = fl;
    new_pc          = npc;
    br_taken        = br;
    br_addr         = baddr;
    bus.bus_ack     = ack;
    bus.bus_rd_data = data;
    #1;
    fetching = (m_parked.size() == 0);
    check_eq("bus_req", 32'(bus.bus_req), 32'(!rst && fetching));
    if (!rst) begin
      check_eq("busy", 32'(busy), 32'(fetching && !ack));
      if (fetching) check_eq("bus_addr", bus.bus_addr, m_pc);
    end

    if (rst) begin
      m_pc      = 32'h0;
      m_parked.delete();
      m_if_pc   = 32'h0;
      m_if_insn = Nop;
      m_if_en   = 1'b0;
    end else if (fl) begin
      m_pc      = npc & 32'hFFFF_FFFC;
      m_parked.delete();
      m_if_en   = 1'b0;
      m_if_insn = Nop;
    end else if (st) begin
      if (fetching && ack) m_parked.push_back(data);
    end else if (!fetching) begin
      deliver(m_parked.pop_front(), br, baddr);
    end else if (ack) begin
      deliver(data, br, baddr);
    end else begin
      m_if_en = 1'b0;
    end

    @(posedge clk);
    #1;
    check_eq("if_pc", if_pc, m_if_pc);
    check_eq("if_insn", if_insn, m_if_insn);
    check_eq("if_en", 32'(if_en), 32'(m_if_en));
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    cycle(1, 1, 1, 32'h100, 0, 32'h0, 1, 32'hDEAD);
  endtask

  initial begin
    m_pc = 32'h0; m_if_pc = 32'h0; m_if_insn = Nop; m_if_en = 1'b0;

    // Reset values.
    do_reset();
    check_eq("rst_if_pc", if_pc, 32'h0);
    check_eq("rst_if_insn", if_insn, Nop);
    check_eq("rst_if_en", 32'(if_en), 32'h0);
    check_eq("rst_bus_req", 32'(bus.bus_req), 32'h0);

    // Back-to-back acks deliver 0,4,8 on consecutive cycles.
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 32'h0, 0, 32'h0, 1, 32'hA0 + 32'(i));
      check_eq("seq_if_pc", if_pc, 32'(4 * i));
      check_eq("seq_if_insn", if_insn, 32'hA0 + 32'(i));
      check_eq("seq_if_en", 32'(if_en), 32'h1);
    end

    // Ack delayed two cycles at 0x8 with stall following busy.
    do_reset();
    cycle(0, 0, 0, 32'h0, 0, 32'h0, 1, 32'hB0);
    cycle(0, 0, 0, 32'h0, 0, 32'h0, 1, 32'hB4);
    for (int i = 0; i < 2; i++) begin
      cycle(0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0);
      check_eq("wait_busy", 32'(busy), 32'h1);
      check_eq("wait_addr", bus.bus_addr, 32'h8);
      check_eq("wait_if_pc", if_pc, 32'h4);
    end
    cycle(0, 0, 0, 32'h0, 0, 32'h0, 1, 32'hB8);
    check_eq("late_if_pc", if_pc, 32'h8);

    // Ack at 0xC during a 3-cycle stall parks the word.
    cycle(0, 1, 0, 32'h0, 0, 32'h0, 1, 32'hBEEF);
    cycle(0, 1, 0, 32'h0, 0, 32'h0, 1, 32'h1111);
    cycle(0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    check_eq("hold_bus_req", 32'(bus.bus_req), 32'h0);
    check_eq("hold_if_pc", if_pc, 32'h8);
    cycle(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    check_eq("skid_if_insn", if_insn, 32'hBEEF);
    check_eq("skid_if_pc", if_pc, 32'hC);
    check_eq("skid_next_addr", bus.bus_addr, 32'h10);

    // Flush while holding drops the parked word.
    cycle(0, 1, 0, 32'h0, 0, 32'h0, 1, 32'hCAFE);
    cycle(0, 1, 1, 32'h180, 0, 32'h0, 0, 32'h0);
    check_eq("flush_if_en", 32'(if_en), 32'h0);
    check_eq("flush_if_insn", if_insn, Nop);
    check_eq("flush_addr", bus.bus_addr, 32'h180);
    check_eq("flush_bus_req", 32'(bus.bus_req), 32'h1);

    // Taken branch: delay slot at 0x14 kept, target aligned to 0x40.
    cycle(0, 0, 1, 32'h14, 0, 32'h0, 1, 32'h7777);
    cycle(0, 0, 0, 32'h0, 1, 32'h43, 1, 32'h1414);
    check_eq("br_if_pc", if_pc, 32'h14);
    check_eq("br_if_insn", if_insn, 32'h1414);
    check_eq("br_addr_next", bus.bus_addr, 32'h40);

    // PC wraps, then reset wins over a simultaneous flush.
    cycle(0, 0, 1, 32'hFFFF_FFFF, 0, 32'h0, 0, 32'h0);
    check_eq("wrap_addr_hi", bus.bus_addr, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 32'h0, 0, 32'h0, 1, 32'hF0F0);
    check_eq("wrap_addr", bus.bus_addr, 32'h0);
    cycle(0, 1, 0, 32'h0, 0, 32'h0, 1, 32'h5A5A);
    cycle(1, 1, 1, 32'h200, 1, 32'h300, 1, 32'h0);
    check_eq("rstfl_if_en", 32'(if_en), 32'h0);
    check_eq("rstfl_if_pc", if_pc, 32'h0);
    check_eq("rstfl_if_insn", if_insn, Nop);
    cycle(0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    check_eq("rstfl_addr", bus.bus_addr, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(99) < 1, $urandom_range(99) < 30, $urandom_range(99) < 5,
            $urandom, $urandom_range(99) < 10, $urandom, $urandom_range(99) < 60, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
